// File: rtl/tiny16_pkg.sv
// Shared tiny16 definitions: boot loader FSM states, header length and error bit positions.
package tiny16_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StDataHi,
        StDataLo,
        StSetAddr,
        StWrite,
        StCsum,
        StDone
    } loader_state_e;

    localparam int unsigned HDR_BYTES = 4;
    localparam int unsigned ERR_CSUM  = 0;
    localparam int unsigned ERR_RANGE = 1;

endpackage

// File: rtl/mem_loader.sv
// Boot-time program loader: parses a byte stream (header, big-endian words, checksum) and writes
// the words into the tiny16 memory through its MAR load / data write port pair.
module mem_loader
    import tiny16_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_addr_en,
    output logic [15:0] mem_addr,
    output logic        mem_in_en,
    output logic [15:0] mem_in,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err
);

    loader_state_e state_q, state_d;
    logic [1:0]    hdr_idx_q, hdr_idx_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   word_q, word_d;
    logic [7:0]    sum_q, sum_d;
    logic [1:0]    err_q, err_d;

    logic          accept;
    logic [7:0]    sum_next;
    logic [15:0]   cnt_hdr;
    logic [16:0]   end_addr;

    // All outputs decode from registered state only.
    assign rx_ready    = state_q inside {StHdr, StDataHi, StDataLo, StCsum};
    assign mem_addr_en = (state_q == StSetAddr);
    assign mem_addr    = (state_q == StSetAddr) ? addr_q : '0;
    assign mem_in_en   = (state_q == StWrite);
    assign mem_in      = (state_q == StWrite) ? word_q : '0;
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign err         = err_q;

    assign accept   = rx_valid && rx_ready;
    assign sum_next = sum_q + rx_data;
    assign cnt_hdr  = {cnt_q[15:8], rx_data};
    // 17-bit sum so a start address near the top of the 16-bit space cannot wrap past the check.
    assign end_addr = {1'b0, addr_q} + {1'b0, cnt_hdr};

    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        sum_d     = sum_q;
        err_d     = err_q;

        if (accept) begin
            sum_d = sum_next;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_d     = '0;
                    sum_d     = '0;
                    hdr_idx_d = '0;
                    state_d   = StHdr;
                end
            end
            StHdr: begin
                if (accept) begin
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    if (hdr_idx_q == 2'd0) begin
                        addr_d[15:8] = rx_data;
                    end else if (hdr_idx_q == 2'd1) begin
                        addr_d[7:0] = rx_data;
                    end else if (hdr_idx_q != 2'(HDR_BYTES - 1)) begin
                        cnt_d[15:8] = rx_data;
                    end else begin
                        cnt_d[7:0]       = rx_data;
                        err_d[ERR_RANGE] = (end_addr > 17'(MEM_SIZE));
                        state_d          = (cnt_hdr != 16'd0) ? StDataHi : StCsum;
                    end
                end
            end
            StDataHi: begin
                if (accept) begin
                    word_d[15:8] = rx_data;
                    state_d      = StDataLo;
                end
            end
            StDataLo: begin
                if (accept) begin
                    word_d[7:0] = rx_data;
                    if (err_q[ERR_RANGE]) begin
                        // Out-of-range load: keep consuming and summing, never touch memory.
                        cnt_d   = cnt_q - 16'd1;
                        state_d = (cnt_q == 16'd1) ? StCsum : StDataHi;
                    end else begin
                        state_d = StSetAddr;
                    end
                end
            end
            StSetAddr: begin
                state_d = StWrite;
            end
            StWrite: begin
                addr_d  = addr_q + 16'd1;
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? StCsum : StDataHi;
            end
            StCsum: begin
                if (accept) begin
                    if (sum_next != 8'd0) begin
                        err_d[ERR_CSUM] = 1'b1;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            hdr_idx_q <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            sum_q     <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            sum_q     <= sum_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed and random streams against a stream-level model.
module tb_mem_loader;

    localparam int unsigned MEM_SIZE = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_addr_en;
    logic [15:0] mem_addr;
    logic        mem_in_en;
    logic [15:0] mem_in;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    mem_loader #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .mem_addr_en (mem_addr_en),
        .mem_addr    (mem_addr),
        .mem_in_en   (mem_in_en),
        .mem_in      (mem_in),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Downstream memory model plus protocol monitors, sampled mid-cycle.
    logic [15:0] mar = '0;
    logic [15:0] mem [0:MEM_SIZE-1];
    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          acc_bytes   = 0;
    int          done_pulses = 0;
    int          proto_viol  = 0;
    logic [1:0]  err_at_done = '0;
    int          cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && rx_ready) acc_bytes++;
        if (mem_addr_en && mem_in_en) proto_viol++;
        if (rx_ready && (mem_addr_en || mem_in_en)) proto_viol++;
        if (!mem_addr_en && mem_addr != 16'd0) proto_viol++;
        if (!mem_in_en && mem_in != 16'd0) proto_viol++;
        if (mem_addr_en) mar = mem_addr;
        if (mem_in_en) begin
            wr_addr_q.push_back(mar);
            wr_data_q.push_back(mem_in);
            mem[mar[7:0]] = mem_in;
        end
        if (done) begin
            done_pulses++;
            err_at_done = err;
        end
    end

    logic [7:0]  stream[$];
    logic [15:0] exp_addr[$];
    logic [15:0] exp_data[$];

    task automatic make_stream(input logic [15:0] a, input logic [15:0] n, input bit bad);
        logic [7:0] s;
        s = 8'd0;
        stream.delete();
        stream.push_back(a[15:8]);
        stream.push_back(a[7:0]);
        stream.push_back(n[15:8]);
        stream.push_back(n[7:0]);
        for (int i = 0; i < 2 * int'(n); i++) stream.push_back(8'($urandom));
        foreach (stream[i]) s += stream[i];
        stream.push_back(8'(8'd0 - s) ^ (bad ? 8'h01 : 8'h00));
    endtask

    // Expected outcome straight from the stream format rules.
    task automatic model(output logic [1:0] e, output int cycles);
        int         a;
        int         n;
        bit         range;
        logic [7:0] s;
        a = int'({stream[0], stream[1]});
        n = int'({stream[2], stream[3]});
        s = 8'd0;
        foreach (stream[i]) s += stream[i];
        range = (a + n) > int'(MEM_SIZE);
        exp_addr.delete();
        exp_data.delete();
        if (!range) begin
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(16'(a + i));
                exp_data.push_back({stream[4 + 2 * i], stream[5 + 2 * i]});
            end
        end
        e = {range, s != 8'd0};
        cycles = 4 + n * (range ? 2 : 4) + 1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gappy, input bit poke, output bit ok);
        int guard;
        ok    = 1'b1;
        guard = 0;
        if (gappy) begin
            while ($urandom_range(0, 1) == 0 && guard < 6) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(posedge clk);
                #1;
                guard++;
            end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        start    = poke;
        guard    = 0;
        while (!rx_ready) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            guard++;
            if (guard > 50) begin
                ok       = 1'b0;
                rx_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_session(input string name, input bit gappy, input int poke_at);
        logic [1:0] e;
        int         cycles;
        int         t0;
        bit         ok;
        model(e, cycles);
        wr_addr_q.delete();
        wr_data_q.delete();
        acc_bytes   = 0;
        done_pulses = 0;
        proto_viol  = 0;
        pulse_start();
        check_eq({name, "_busy_rise"}, 32'(busy), 32'd1);
        t0 = cyc;
        ok = 1'b1;
        foreach (stream[i]) begin
            if (ok) send_byte(stream[i], gappy, i == poke_at, ok);
        end
        if (!ok) begin
            check_eq({name, "_rx_timeout"}, 32'd1, 32'd0);
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            return;
        end
        check_eq({name, "_done_timing"}, 32'(done), 32'd1);
        if (!gappy) check_eq({name, "_cycles"}, 32'(cyc - t0), 32'(cycles));
        @(posedge clk);
        #1;
        check_eq({name, "_busy_fall"}, 32'({busy, done}), 32'd0);
        check_eq({name, "_bytes"}, 32'(acc_bytes), 32'(stream.size()));
        check_eq({name, "_done_cnt"}, 32'(done_pulses), 32'd1);
        check_eq({name, "_err"}, 32'(err_at_done), 32'(e));
        check_eq({name, "_proto"}, 32'(proto_viol), 32'd0);
        check_eq({name, "_nwrites"}, 32'(wr_addr_q.size()), 32'(exp_addr.size()));
        if (wr_addr_q.size() == exp_addr.size()) begin
            foreach (exp_addr[i]) begin
                check_eq({name, "_waddr"}, 32'(wr_addr_q[i]), 32'(exp_addr[i]));
                check_eq({name, "_wdata"}, 32'(wr_data_q[i]), 32'(exp_data[i]));
                check_eq({name, "_mem"}, 32'(mem[exp_addr[i][7:0]]), 32'(exp_data[i]));
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check_eq({name, "_ctl"}, 32'({rx_ready, mem_addr_en, mem_in_en, busy, done, err}), 32'd0);
        check_eq({name, "_maddr"}, 32'(mem_addr), 32'd0);
        check_eq({name, "_min"}, 32'(mem_in), 32'd0);
    endtask

    initial begin
        bit ok;
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        stream = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h30};
        run_session("normal", 1'b0, -1);

        stream = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h31};
        run_session("badcsum", 1'b0, -1);

        // Range error, with a stray start mid-session that must not clear err.
        make_stream(16'h00FF, 16'd2, 1'b0);
        run_session("range", 1'b0, 5);

        stream = '{8'h00, 8'h20, 8'h00, 8'h00, 8'hE0};
        run_session("zero", 1'b0, -1);

        stream = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h30};
        run_session("gappy", 1'b1, -1);

        // Reset after the third data byte.
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(stream[i], 1'b0, 1'b0, ok);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_outputs("midrst");
        run_session("after_rst", 1'b0, -1);

        for (int k = 0; k < 12; k++) begin
            logic [15:0] a;
            logic [15:0] n;
            a = ($urandom_range(0, 7) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                            : 16'($urandom_range(0, 255));
            n = 16'($urandom_range(0, 6));
            make_stream(a, n, $urandom_range(0, 3) == 0);
            run_session("rand", $urandom_range(0, 1) == 1,
                        ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
